// File: rtl/conv_transpose2d_if.sv
// Memory-port and control bundle for conv_transpose2d.
// master = the datapath, slave = the memories/host that serve it.
interface conv_transpose2d_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic                  start;
    logic                  done;
    logic                  valid;
    logic [ADDR_WIDTH-1:0] input_addr;
    logic [ADDR_WIDTH-1:0] weight_addr;
    logic [ADDR_WIDTH-1:0] bias_addr;
    logic [ADDR_WIDTH-1:0] output_addr;
    logic [DATA_WIDTH-1:0] input_data;
    logic [DATA_WIDTH-1:0] weight_data;
    logic [DATA_WIDTH-1:0] bias_data;
    logic [DATA_WIDTH-1:0] output_data;
    logic                  input_en;
    logic                  weight_en;
    logic                  bias_en;
    logic                  output_en;
    logic                  output_we;

    modport master (
        input  start, input_data, weight_data, bias_data,
        output done, valid,
        output input_addr, weight_addr, bias_addr, output_addr,
        output input_en, weight_en, bias_en,
        output output_data, output_en, output_we
    );

    modport slave (
        output start, input_data, weight_data, bias_data,
        input  done, valid,
        input  input_addr, weight_addr, bias_addr, output_addr,
        input  input_en, weight_en, bias_en,
        input  output_data, output_en, output_we
    );
endinterface

// File: rtl/conv_transpose2d.sv
// Gather-form 2-D transposed convolution: one output pixel per
// BIAS + IC*K*K tap cycles + WRITE, raster order over (b, oc, oy, ox).
module conv_transpose2d #(
    parameter int BATCH_SIZE   = 1,
    parameter int IN_CHANNELS  = 1,
    parameter int OUT_CHANNELS = 2,
    parameter int IN_HEIGHT    = 2,
    parameter int IN_WIDTH     = 2,
    parameter int KERNEL_SIZE  = 2,
    parameter int STRIDE       = 2,
    parameter int PADDING      = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16
) (
    input  logic clk,
    input  logic rst,
    conv_transpose2d_if.master bus
);
    localparam int OUT_HEIGHT = (IN_HEIGHT - 1) * STRIDE - 2 * PADDING + KERNEL_SIZE;
    localparam int OUT_WIDTH  = (IN_WIDTH - 1) * STRIDE - 2 * PADDING + KERNEL_SIZE;
    localparam int AW = ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int SW = AW + 2;

    localparam logic [AW-1:0] ICA = AW'(IN_CHANNELS);
    localparam logic [AW-1:0] OCA = AW'(OUT_CHANNELS);
    localparam logic [AW-1:0] IHA = AW'(IN_HEIGHT);
    localparam logic [AW-1:0] IWA = AW'(IN_WIDTH);
    localparam logic [AW-1:0] KA  = AW'(KERNEL_SIZE);
    localparam logic [AW-1:0] OHA = AW'(OUT_HEIGHT);
    localparam logic [AW-1:0] OWA = AW'(OUT_WIDTH);

    localparam logic [AW-1:0] LAST_B  = AW'(BATCH_SIZE - 1);
    localparam logic [AW-1:0] LAST_OC = AW'(OUT_CHANNELS - 1);
    localparam logic [AW-1:0] LAST_OH = AW'(OUT_HEIGHT - 1);
    localparam logic [AW-1:0] LAST_OW = AW'(OUT_WIDTH - 1);
    localparam logic [AW-1:0] LAST_IC = AW'(IN_CHANNELS - 1);
    localparam logic [AW-1:0] LAST_K  = AW'(KERNEL_SIZE - 1);

    localparam logic signed [SW-1:0] PS  = SW'(PADDING);
    localparam logic signed [SW-1:0] SS  = SW'(STRIDE);
    localparam logic signed [SW-1:0] IHS = SW'(IN_HEIGHT);
    localparam logic signed [SW-1:0] IWS = SW'(IN_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIAS,
        S_ACC,
        S_WRITE,
        S_DONE
    } state_e;

    state_e state_q, state_d;
    logic [AW-1:0] b_q, b_d, oc_q, oc_d, oy_q, oy_d, ox_q, ox_d;
    logic [AW-1:0] ic_q, ic_d, ky_q, ky_d, kx_q, kx_d;
    logic [DW-1:0] acc_q, acc_d;

    logic signed [SW-1:0] ty, tx, iy_s, ix_s;
    logic [AW-1:0] iy, ix;
    logic tap_ok;

    // Gather: input (iy,ix) feeds this output through tap (ky,kx) only
    // when oy+P-ky lands exactly on a stride point inside the input.
    always_comb begin
        ty     = $signed({2'b00, oy_q}) + PS - $signed({2'b00, ky_q});
        tx     = $signed({2'b00, ox_q}) + PS - $signed({2'b00, kx_q});
        iy_s   = ty / SS;
        ix_s   = tx / SS;
        iy     = iy_s[AW-1:0];
        ix     = ix_s[AW-1:0];
        tap_ok = !ty[SW-1] && !tx[SW-1]
              && (ty % SS == '0) && (tx % SS == '0)
              && (iy_s < IHS) && (ix_s < IWS);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            b_q     <= '0;
            oc_q    <= '0;
            oy_q    <= '0;
            ox_q    <= '0;
            ic_q    <= '0;
            ky_q    <= '0;
            kx_q    <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            oc_q    <= oc_d;
            oy_q    <= oy_d;
            ox_q    <= ox_d;
            ic_q    <= ic_d;
            ky_q    <= ky_d;
            kx_q    <= kx_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        oc_d    = oc_q;
        oy_d    = oy_q;
        ox_d    = ox_q;
        ic_d    = ic_q;
        ky_d    = ky_q;
        kx_d    = kx_q;
        acc_d   = acc_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) state_d = S_BIAS;
            end
            S_BIAS: begin
                acc_d   = bus.bias_data;
                state_d = S_ACC;
            end
            S_ACC: begin
                if (tap_ok) acc_d = acc_q + bus.input_data * bus.weight_data;
                if (kx_q == LAST_K) begin
                    kx_d = '0;
                    if (ky_q == LAST_K) begin
                        ky_d = '0;
                        if (ic_q == LAST_IC) begin
                            ic_d    = '0;
                            state_d = S_WRITE;
                        end else begin
                            ic_d = ic_q + 1'b1;
                        end
                    end else begin
                        ky_d = ky_q + 1'b1;
                    end
                end else begin
                    kx_d = kx_q + 1'b1;
                end
            end
            S_WRITE: begin
                state_d = S_BIAS;
                if (ox_q == LAST_OW) begin
                    ox_d = '0;
                    if (oy_q == LAST_OH) begin
                        oy_d = '0;
                        if (oc_q == LAST_OC) begin
                            oc_d = '0;
                            if (b_q == LAST_B) begin
                                b_d     = '0;
                                state_d = S_DONE;
                            end else begin
                                b_d = b_q + 1'b1;
                            end
                        end else begin
                            oc_d = oc_q + 1'b1;
                        end
                    end else begin
                        oy_d = oy_q + 1'b1;
                    end
                end else begin
                    ox_d = ox_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.done        = 1'b0;
        bus.valid       = 1'b0;
        bus.input_en    = 1'b0;
        bus.weight_en   = 1'b0;
        bus.bias_en     = 1'b0;
        bus.output_en   = 1'b0;
        bus.output_we   = 1'b0;
        bus.input_addr  = '0;
        bus.weight_addr = '0;
        bus.bias_addr   = '0;
        bus.output_addr = '0;
        bus.output_data = '0;
        unique case (state_q)
            S_BIAS: begin
                bus.bias_en   = 1'b1;
                bus.bias_addr = oc_q;
            end
            S_ACC: begin
                if (tap_ok) begin
                    bus.input_en    = 1'b1;
                    bus.weight_en   = 1'b1;
                    bus.input_addr  = ((b_q * ICA + ic_q) * IHA + iy) * IWA + ix;
                    bus.weight_addr = ((ic_q * OCA + oc_q) * KA + ky_q) * KA + kx_q;
                end
            end
            S_WRITE: begin
                bus.valid       = 1'b1;
                bus.output_en   = 1'b1;
                bus.output_we   = 1'b1;
                bus.output_addr = ((b_q * OCA + oc_q) * OHA + oy_q) * OWA + ox_q;
                bus.output_data = acc_q;
            end
            S_DONE: bus.done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_conv_transpose2d.sv
// Bench for conv_transpose2d: three configurations (default, IC=2,
// K=3/P=1) checked against a scatter-form reference model.
module tb_conv_transpose2d;
    logic clk;
    logic rst;
    logic sa, sb, sc;
    int cyc = 0;
    int checks = 0;
    int failures = 0;

    conv_transpose2d_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) ifa ();
    conv_transpose2d_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) ifb ();
    conv_transpose2d_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) ifc ();

    conv_transpose2d u_a (.clk(clk), .rst(rst), .bus(ifa));
    conv_transpose2d #(.IN_CHANNELS(2)) u_b (.clk(clk), .rst(rst), .bus(ifb));
    conv_transpose2d #(.OUT_CHANNELS(1), .KERNEL_SIZE(3), .PADDING(1))
        u_c (.clk(clk), .rst(rst), .bus(ifc));

    int a_in[64], a_w[64], a_b[64];
    int b_in[64], b_w[64], b_b[64];
    int c_in[64], c_w[64], c_b[64];

    assign ifa.start       = sa;
    assign ifa.input_data  = ifa.input_en  ? a_in[ifa.input_addr[5:0]]  : '0;
    assign ifa.weight_data = ifa.weight_en ? a_w[ifa.weight_addr[5:0]]  : '0;
    assign ifa.bias_data   = ifa.bias_en   ? a_b[ifa.bias_addr[5:0]]    : '0;
    assign ifb.start       = sb;
    assign ifb.input_data  = ifb.input_en  ? b_in[ifb.input_addr[5:0]]  : '0;
    assign ifb.weight_data = ifb.weight_en ? b_w[ifb.weight_addr[5:0]]  : '0;
    assign ifb.bias_data   = ifb.bias_en   ? b_b[ifb.bias_addr[5:0]]    : '0;
    assign ifc.start       = sc;
    assign ifc.input_data  = ifc.input_en  ? c_in[ifc.input_addr[5:0]]  : '0;
    assign ifc.weight_data = ifc.weight_en ? c_w[ifc.weight_addr[5:0]]  : '0;
    assign ifc.bias_data   = ifc.bias_en   ? c_b[ifc.bias_addr[5:0]]    : '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write logs, pulse counts and idle-output violations per instance.
    int a_la[1024], a_ld[1024], b_la[1024], b_ld[1024], c_la[1024], c_ld[1024];
    int a_wr = 0, b_wr = 0, c_wr = 0, a_vld = 0, a_last = 0, b_last = 0;
    int a_ien = 0, c_ien = 0, a_bad = 0, b_bad = 0, c_bad = 0;

    always @(posedge clk) begin
        if (ifa.output_en && ifa.output_we) begin
            a_la[a_wr % 1024] <= int'(ifa.output_addr);
            a_ld[a_wr % 1024] <= int'(ifa.output_data);
            a_wr   <= a_wr + 1;
            a_last <= cyc;
        end
        if (ifa.valid) a_vld <= a_vld + 1;
        if (ifa.input_en) a_ien <= a_ien + 1;
        if ((!ifa.input_en && ifa.input_addr != 0) || (!ifa.weight_en && ifa.weight_addr != 0)
            || (!ifa.bias_en && ifa.bias_addr != 0) || (!ifa.output_en && (ifa.output_addr != 0
            || ifa.output_data != 0)) || ifa.valid != ifa.output_en || ifa.output_we != ifa.output_en
            || ifa.input_en != ifa.weight_en)
            a_bad <= a_bad + 1;
    end

    always @(posedge clk) begin
        if (ifb.output_en && ifb.output_we) begin
            b_la[b_wr % 1024] <= int'(ifb.output_addr);
            b_ld[b_wr % 1024] <= int'(ifb.output_data);
            b_wr   <= b_wr + 1;
            b_last <= cyc;
        end
        if ((!ifb.input_en && ifb.input_addr != 0) || (!ifb.output_en && ifb.output_data != 0)
            || ifb.valid != ifb.output_en)
            b_bad <= b_bad + 1;
    end

    always @(posedge clk) begin
        if (ifc.output_en && ifc.output_we) begin
            c_la[c_wr % 1024] <= int'(ifc.output_addr);
            c_ld[c_wr % 1024] <= int'(ifc.output_data);
            c_wr <= c_wr + 1;
        end
        if (ifc.input_en) c_ien <= c_ien + 1;
        if ((!ifc.input_en && ifc.input_addr != 0) || (!ifc.weight_en && ifc.weight_addr != 0)
            || (!ifc.output_en && ifc.output_data != 0) || ifc.valid != ifc.output_en)
            c_bad <= c_bad + 1;
    end

    // Scatter form: every input pixel deposits in*w at oy = iy*S-P+ky.
    function automatic void model(input int icn, input int ocn, input int ih, input int iw,
                                  input int k, input int s, input int p,
                                  input int im[64], input int wm[64], input int bm[64],
                                  output int o[64]);
        int oh, ow, y, x;
        oh = (ih - 1) * s - 2 * p + k;
        ow = (iw - 1) * s - 2 * p + k;
        for (int i = 0; i < 64; i++) o[i] = 0;
        for (int oc = 0; oc < ocn; oc++)
            for (int i = 0; i < oh * ow; i++) o[oc * oh * ow + i] = bm[oc];
        for (int ic = 0; ic < icn; ic++)
            for (int iy = 0; iy < ih; iy++)
                for (int ix = 0; ix < iw; ix++)
                    for (int oc = 0; oc < ocn; oc++)
                        for (int ky = 0; ky < k; ky++)
                            for (int kx = 0; kx < k; kx++) begin
                                y = iy * s - p + ky;
                                x = ix * s - p + kx;
                                if (y >= 0 && y < oh && x >= 0 && x < ow)
                                    o[(oc * oh + y) * ow + x] +=
                                        im[(ic * ih + iy) * iw + ix] * wm[((ic * ocn + oc) * k + ky) * k + kx];
                            end
    endfunction

    task automatic drive_start(input int which, input logic v);
        case (which)
            0: sa = v;
            1: sb = v;
            default: sc = v;
        endcase
    endtask

    function automatic logic done_of(input int which);
        case (which)
            0: return ifa.done;
            1: return ifb.done;
            default: return ifc.done;
        endcase
    endfunction

    // Start a run; k0 is the edge that samples start, fd the first done cycle.
    task automatic run(input int which, input int glitch, output int k0, output int fd);
        @(negedge clk);
        drive_start(which, 1'b1);
        @(posedge clk);
        k0 = cyc;
        #1 drive_start(which, 1'b0);
        fd = -1;
        for (int i = 0; i < 1000 && fd < 0; i++) begin
            @(negedge clk);
            if (done_of(which)) fd = cyc - k0;
            else if (glitch > 0 && cyc - k0 == glitch) begin
                drive_start(which, 1'b1);
                @(posedge clk);
                #1 drive_start(which, 1'b0);
            end
        end
    endtask

    task automatic load_default_a();
        for (int i = 0; i < 4; i++) a_in[i] = i;
        for (int i = 0; i < 8; i++) a_w[i] = 1;
        a_b[0] = 0;
        a_b[1] = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({ifa.done, ifa.valid, ifa.input_en, ifa.weight_en, ifa.bias_en, ifa.output_en,
             ifa.output_we, ifa.input_addr, ifa.weight_addr, ifa.bias_addr, ifa.output_addr,
             ifa.output_data} !== '0) begin
            failures++;
            $display("FAIL reset_outputs_a done=%b valid=%b ien=%b oen=%b want all 0",
                     ifa.done, ifa.valid, ifa.input_en, ifa.output_en);
        end
        checks++;
        if ({ifb.done, ifb.valid, ifc.done, ifc.valid, ifb.bias_en, ifc.bias_en} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs_bc done=%b/%b want 0", ifb.done, ifc.done);
        end
    endtask

    task automatic test_upsample();
        int m[64];
        int k0, fd, base, vb, bad;
        load_default_a();
        model(1, 2, 2, 2, 2, 2, 0, a_in, a_w, a_b, m);
        base = a_wr;
        vb = a_vld;
        run(0, 0, k0, fd);
        for (int j = 0; j < 32; j++) begin
            checks++;
            if (a_la[(base + j) % 1024] !== j || a_ld[(base + j) % 1024] !== m[j]) begin
                failures++;
                $display("FAIL upsample_pix%0d got addr=%0d data=%0d want addr=%0d data=%0d",
                         j, a_la[(base + j) % 1024], a_ld[(base + j) % 1024], j, m[j]);
            end
        end
        bad = 0;
        for (int j = 0; j < 16; j++)
            if (a_ld[(base + j) % 1024] !== ((j / 8) * 2 + (j % 4) / 2)) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL upsample_ch0_pattern got %0d wrong pixels want 0", bad);
        end
        checks++;
        if (a_vld - vb !== 32) begin
            failures++;
            $display("FAIL upsample_valid_pulses got %0d want 32", a_vld - vb);
        end
        checks++;
        if (fd !== 193) begin
            failures++;
            $display("FAIL upsample_done_cycle got %0d want 193", fd);
        end
        checks++;
        if (a_last - k0 !== 192) begin
            failures++;
            $display("FAIL upsample_last_write got %0d want 192", a_last - k0);
        end
    endtask

    task automatic test_bias_sign();
        int m[64];
        int k0, fd, base, bad;
        load_default_a();
        a_b[0] = 5;
        a_b[1] = -3;
        model(1, 2, 2, 2, 2, 2, 0, a_in, a_w, a_b, m);
        base = a_wr;
        run(0, 0, k0, fd);
        bad = 0;
        for (int j = 0; j < 32; j++) if (a_ld[(base + j) % 1024] !== m[j]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bias_pixels got %0d wrong pixels want 0", bad);
        end
        checks++;
        if (a_ld[(base + 16) % 1024] !== 32'hFFFFFFFD) begin
            failures++;
            $display("FAIL bias_out16 got %h want fffffffd", a_ld[(base + 16) % 1024]);
        end
        for (int i = 0; i < 4; i++) a_in[i] = -2;
        for (int i = 0; i < 8; i++) a_w[i] = 3;
        a_b[0] = 0;
        a_b[1] = 0;
        base = a_wr;
        run(0, 0, k0, fd);
        bad = 0;
        for (int j = 0; j < 16; j++) if (a_ld[(base + j) % 1024] !== -6) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL sign_ch0 got %0d pixels not -6 want 0", bad);
        end
    endtask

    task automatic test_random();
        int m[64];
        int k0, fd, base, bad;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) a_in[i] = $urandom;
            for (int i = 0; i < 8; i++) a_w[i] = (r == 0) ? $urandom_range(0, 20) - 10 : $urandom;
            a_b[0] = $urandom;
            a_b[1] = $urandom;
            model(1, 2, 2, 2, 2, 2, 0, a_in, a_w, a_b, m);
            base = a_wr;
            run(0, 0, k0, fd);
            bad = 0;
            for (int j = 0; j < 32; j++) if (a_ld[(base + j) % 1024] !== m[j]) bad++;
            checks++;
            if (bad != 0 || fd != 193) begin
                failures++;
                $display("FAIL random_a%0d got %0d wrong pixels done=%0d want 0 and 193", r, bad, fd);
            end
        end
    endtask

    task automatic test_padding();
        int exp9[9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
        int m[64];
        int k0, fd, base, ie, bad;
        for (int i = 0; i < 4; i++) c_in[i] = 1;
        for (int i = 0; i < 9; i++) c_w[i] = 1;
        c_b[0] = 0;
        base = c_wr;
        ie = c_ien;
        run(2, 0, k0, fd);
        for (int j = 0; j < 9; j++) begin
            checks++;
            if (c_la[(base + j) % 1024] !== j || c_ld[(base + j) % 1024] !== exp9[j]) begin
                failures++;
                $display("FAIL pad_pix%0d got addr=%0d data=%0d want addr=%0d data=%0d",
                         j, c_la[(base + j) % 1024], c_ld[(base + j) % 1024], j, exp9[j]);
            end
        end
        checks++;
        if (c_ien - ie !== 16 || fd !== 9 * 11 + 1) begin
            failures++;
            $display("FAIL pad_input_en got %0d taps done=%0d want 16 and 100", c_ien - ie, fd);
        end
        for (int i = 0; i < 4; i++) c_in[i] = $urandom;
        for (int i = 0; i < 9; i++) c_w[i] = $urandom;
        c_b[0] = $urandom;
        model(1, 1, 2, 2, 3, 2, 1, c_in, c_w, c_b, m);
        base = c_wr;
        run(2, 0, k0, fd);
        bad = 0;
        for (int j = 0; j < 9; j++) if (c_ld[(base + j) % 1024] !== m[j]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL pad_random got %0d wrong pixels want 0", bad);
        end
    endtask

    task automatic test_multichannel();
        int m[64];
        int k0, fd, base, bad;
        for (int i = 0; i < 8; i++) b_in[i] = i;
        for (int i = 0; i < 16; i++) b_w[i] = 1;
        b_b[0] = 0;
        b_b[1] = 0;
        base = b_wr;
        run(1, 0, k0, fd);
        checks++;
        if (b_ld[base % 1024] !== 4 || b_ld[(base + 15) % 1024] !== 10) begin
            failures++;
            $display("FAIL multi_spot got %0d,%0d want 4,10", b_ld[base % 1024], b_ld[(base + 15) % 1024]);
        end
        checks++;
        if (fd !== 321 || b_last - k0 !== 320 || b_wr - base !== 32) begin
            failures++;
            $display("FAIL multi_timing got done=%0d last=%0d n=%0d want 321 320 32",
                     fd, b_last - k0, b_wr - base);
        end
        for (int i = 0; i < 8; i++) b_in[i] = $urandom;
        for (int i = 0; i < 16; i++) b_w[i] = $urandom;
        b_b[0] = $urandom;
        b_b[1] = $urandom;
        model(2, 2, 2, 2, 2, 2, 0, b_in, b_w, b_b, m);
        base = b_wr;
        run(1, 0, k0, fd);
        bad = 0;
        for (int j = 0; j < 32; j++)
            if (b_la[(base + j) % 1024] !== j || b_ld[(base + j) % 1024] !== m[j]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL multi_random got %0d wrong pixels want 0", bad);
        end
    endtask

    task automatic test_control();
        int m[64];
        int k0, fd, base, bad, wr0, ie0;
        load_default_a();
        model(1, 2, 2, 2, 2, 2, 0, a_in, a_w, a_b, m);
        base = a_wr;
        run(0, 3, k0, fd);
        bad = 0;
        for (int j = 0; j < 32; j++) if (a_ld[(base + j) % 1024] !== m[j]) bad++;
        checks++;
        if (bad != 0 || fd !== 193 || a_wr - base !== 32) begin
            failures++;
            $display("FAIL start_in_acc got %0d bad done=%0d n=%0d want 0 193 32", bad, fd, a_wr - base);
        end
        @(negedge clk);
        sa = 1'b1;
        @(posedge clk);
        k0 = cyc;
        #1 sa = 1'b0;
        while (cyc - k0 < 50) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({ifa.done, ifa.valid, ifa.input_en, ifa.weight_en, ifa.bias_en, ifa.output_en,
             ifa.output_we, ifa.input_addr, ifa.weight_addr, ifa.bias_addr, ifa.output_addr,
             ifa.output_data} !== '0) begin
            failures++;
            $display("FAIL midrun_reset got ien=%b ben=%b oen=%b want all outputs 0",
                     ifa.input_en, ifa.bias_en, ifa.output_en);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wr0 = a_wr;
        ie0 = a_ien;
        repeat (10) @(negedge clk);
        checks++;
        if (a_wr !== wr0 || a_ien !== ie0 || ifa.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got writes=%0d reads=%0d done=%b want 0 0 0",
                     a_wr - wr0, a_ien - ie0, ifa.done);
        end
        for (int r = 0; r < 2; r++) begin
            base = a_wr;
            run(0, 0, k0, fd);
            bad = 0;
            for (int j = 0; j < 32; j++)
                if (a_la[(base + j) % 1024] !== j || a_ld[(base + j) % 1024] !== m[j]) bad++;
            checks++;
            if (bad != 0 || fd !== 193 || a_last - k0 !== 192) begin
                failures++;
                $display("FAIL restart%0d got %0d bad done=%0d last=%0d want 0 193 192",
                         r, bad, fd, a_last - k0);
            end
        end
    endtask

    task automatic test_inactive();
        @(negedge clk);
        checks++;
        if (a_bad !== 0 || b_bad !== 0 || c_bad !== 0) begin
            failures++;
            $display("FAIL inactive_outputs got %0d/%0d/%0d violations want 0", a_bad, b_bad, c_bad);
        end
    endtask

    initial begin
        rst = 1'b0;
        sa = 1'b0;
        sb = 1'b0;
        sc = 1'b0;
        for (int i = 0; i < 64; i++) begin
            a_in[i] = 0; a_w[i] = 0; a_b[i] = 0;
            b_in[i] = 0; b_w[i] = 0; b_b[i] = 0;
            c_in[i] = 0; c_w[i] = 0; c_b[i] = 0;
        end
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b1;
        test_upsample();
        test_bias_sign();
        test_random();
        test_padding();
        test_multichannel();
        test_control();
        test_inactive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/conv_transpose2d.md
# conv_transpose2d

Memory-mapped 2-D transposed convolution (stride-s upsampler), the decoder-side counterpart of the `conv2d` downsampler in the HCVC-HEM datapath. It reads an input tensor, weights and bias through the same combinational-read memory ports as `conv2d`. It computes each output pixel by gathering over all contributing taps, one tap per cycle, and writes the result to an output memory. Output geometry and weight layout match PyTorch `ConvTranspose2d` with `output_padding = 0`, `groups = 1` and `dilation = 1`.

## Interface
- BATCH_SIZE, 1, batch count
- IN_CHANNELS, 1, input channels (IC)
- OUT_CHANNELS, 2, output channels (OC)
- IN_HEIGHT / IN_WIDTH, 2 / 2, input spatial size
- KERNEL_SIZE, 2, square kernel K
- STRIDE, 2, upsampling stride S
- PADDING, 0, P; requires P < K
- DATA_WIDTH, 32, signed two's-complement word
- ADDR_WIDTH, 16, memory address width
- Derived: OUT_HEIGHT = (IN_HEIGHT-1)*S - 2P + K; OUT_WIDTH is defined the same way.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  starts a run when sampled high in IDLE
- done  out  1  high in DONE state
- valid  out  1  high on each output-write cycle
- input_addr / weight_addr / bias_addr  out  ADDR_WIDTH  read addresses
- input_data / weight_data / bias_data  in  DATA_WIDTH  read data, valid in the same cycle as addr/en
- input_en / weight_en / bias_en  out  1  read enables
- output_addr  out  ADDR_WIDTH  write address
- output_data  out  DATA_WIDTH  write data
- output_en / output_we  out  1  write strobe; both are high together for one cycle per pixel

## Operation
- Address maps:
  - input: ((b*IC+ic)*IN_HEIGHT+iy)*IN_WIDTH+ix
  - weight: ((ic*OC+oc)*K+ky)*K+kx
  - output: ((b*OC+oc)*OUT_HEIGHT+oy)*OUT_WIDTH+ox
- Output pixels are produced in raster order (b, oc, oy, ox), with ox fastest.
- Gather rule, applied to each tap (ic, ky, kx):
  - ty = oy+P-ky and tx = ox+P-kx.
  - The tap is valid iff ty ≥ 0, tx ≥ 0, ty%S == 0, tx%S == 0, ty/S < IN_HEIGHT and tx/S < IN_WIDTH.
  - When valid, iy = ty/S and ix = tx/S.
- FSM states:
  - IDLE: waits for start.
  - BIAS: one cycle. bias_en=1, bias_addr=oc; the accumulator is loaded with bias_data.
  - ACC: IC*K*K cycles, one tap per cycle; ic is the slowest counter and kx the fastest. On a valid tap, input_en=weight_en=1 and the accumulator adds the product. On an invalid tap, both enables are 0 and the accumulator holds.
  - WRITE: one cycle. output_en=output_we=valid=1 and output_data=acc.
  - After WRITE, the FSM goes to BIAS for the next pixel, or to DONE after the last pixel.
  - DONE: done=1, held until start is sampled high, at which point a new run begins in BIAS.
- Arithmetic:
  - Each product is the signed DATA_WIDTH×DATA_WIDTH product truncated to its low DATA_WIDTH bits.
  - The accumulator is DATA_WIDTH wide and wraps modulo 2^DATA_WIDTH with no saturation.
- Inactive outputs: whenever an enable is 0, its address and data outputs are driven to 0.
- start is ignored in BIAS, ACC and WRITE.
- A reset asserted mid-run aborts immediately. Memory contents already written are left untouched.

## Timing
- Reset values: state=IDLE and all counters and the accumulator are 0. done, valid, every enable, output_we, all addresses and output_data are 0.
- Define cycle 0 as the edge that samples start. BIAS occupies cycle 1, ACC occupies cycles 2..IC*K*K+1, and WRITE occupies cycle IC*K*K+2.
- Per-pixel cost is T = IC*K*K+2 cycles, with no overlap between pixels.
- The last write occurs in cycle N*T, where N = BATCH_SIZE*OC*OUT_HEIGHT*OUT_WIDTH. done rises at cycle N*T+1.
- Defaults: N=32 and T=6, so the last write is at cycle 192 and done=1 from cycle 193.
- The read enables are registered state decodes. A memory must return data combinationally in the same cycle.

## Test plan
- **Default upsample:** input 0..3, weights all 1, bias {0,0}.
  - Each channel is [[0,0,1,1],[0,0,1,1],[2,2,3,3],[2,2,3,3]].
  - Exactly 32 valid pulses; done first high at cycle 193.
- **Bias and sign:** same stimulus with bias {5,-3}.
  - ch0 = previous values +5 and ch1 = previous values -3, e.g. output_mem[16] = 0xFFFFFFFD.
  - A second run with input all -2 and weights all 3 gives -6 in every ch0 pixel when bias=0.
- **Padding/overlap:** IN 2×2, K=3, S=2, P=1, IC=OC=1, input and weights all 1, bias 0.
  - Output is 3×3 [[1,2,1],[2,4,2],[1,2,1]].
  - input_en is low on every invalid tap.
- **Multi-channel:** IC=2 with all other parameters at default; input 0..7, weights all 1.
  - Each pixel is in[c0]+in[c1], e.g. output_mem[0]=4 and output_mem[15]=10.
  - done is first high at cycle 32*10+1.
- **Control:**
  - start pulsed during ACC: no effect on the run.
  - rst asserted at cycle 50: all outputs go to 0 immediately and the FSM returns to IDLE.
  - Restart after reset: reproduces the default result.
  - start during DONE: a second identical run completes with the same timing.
